// File: rtl/sr_flag_arbiter_pkg.sv
// Shared types for the SR flag arbiter: sequencer states and operation encodings.
package sr_flag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT  = 2'd1,
    ST_DRV  = 2'd2,
    ST_CHK  = 2'd3
  } sr_state_e;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/sr_flag_arbiter_if.sv
// Requester-side bundle of the SR flag arbiter: requests in, grant/completion out.
interface sr_flag_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8
);
  localparam int IDXW = $clog2(NFLAG);
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  // A requester holds req/req_op/req_idx stable until its one-cycle gnt pulse;
  // by the edge ending that cycle it drops req or presents a fresh request.
  // Completion comes back later as a one-cycle done with done_id/err qualified by it.
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_op;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ-1:0]      gnt;
  logic                 done;
  logic [IDW-1:0]       done_id;
  logic                 err;
  logic                 busy;

  modport master (
    output req, req_op, req_idx,
    input  gnt, done, done_id, err, busy
  );

  modport slave (
    input  req, req_op, req_idx,
    output gnt, done, done_id, err, busy
  );
endinterface

// File: rtl/sr_flag_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  win_id,
  output logic            win_valid
);

  // Scan offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    win_id    = '0;
    win_valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int             c;
      logic [IDW-1:0] cand;
      c = int'(ptr) + i;
      if (c >= NREQ) c = c - NREQ;
      cand = IDW'(c);
      if (req[cand]) begin
        win_id    = cand;
        win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter/sequencer driving one-cycle set/clear strobes into a shared
// SR flag bank and reporting readback of the addressed flag.
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8
) (
  input  logic               clk,
  input  logic               rst,
  sr_flag_arbiter_if.slave   bus,
  output logic [NFLAG-1:0]   s,
  output logic [NFLAG-1:0]   r,
  input  logic [NFLAG-1:0]   q,
  output sr_state_e          state_dbg
);

  localparam int IDXW = $clog2(NFLAG);
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  sr_state_e       state_q, state_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            op_q, op_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [IDW-1:0]  ptr_inc;
  logic [IDW-1:0]  pick_ptr;
  logic [IDW-1:0]  win_id;
  logic            win_valid;
  logic            win_op;
  logic [IDXW-1:0] win_idx;

  // In CHK the picker already sees the advanced pointer, so the requester
  // that just completed drops to lowest priority for the next pick.
  assign ptr_inc  = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
  assign pick_ptr = (state_q == ST_CHK) ? ptr_inc : rr_ptr_q;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req       (bus.req),
    .ptr       (pick_ptr),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  always_comb begin
    win_op  = OP_CLR;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_id == IDW'(k)) begin
        win_op  = bus.req_op[k];
        win_idx = bus.req_idx[k*IDXW +: IDXW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      id_q     <= '0;
      op_q     <= OP_CLR;
      idx_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    op_d     = op_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          id_d    = win_id;
          op_d    = win_op;
          idx_d   = win_idx;
          state_d = ST_GNT;
        end
      end
      ST_GNT:  state_d = ST_DRV;
      ST_DRV:  state_d = ST_CHK;
      ST_CHK: begin
        rr_ptr_d = ptr_inc;
        if (win_valid) begin
          id_d    = win_id;
          op_d    = win_op;
          idx_d   = win_idx;
          state_d = ST_GNT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are pure decodes of the registered state, so reset clears them all.
  always_comb begin
    bus.gnt     = '0;
    bus.done    = 1'b0;
    bus.done_id = '0;
    bus.err     = 1'b0;
    bus.busy    = (state_q != ST_IDLE);
    s           = '0;
    r           = '0;
    case (state_q)
      ST_GNT: bus.gnt[id_q] = 1'b1;
      ST_DRV: begin
        if (op_q == OP_SET) s[idx_q] = 1'b1;
        else                r[idx_q] = 1'b1;
      end
      ST_CHK: begin
        bus.done    = 1'b1;
        bus.done_id = id_q;
        bus.err     = (q[idx_q] != op_q);
      end
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: doc/sr_flag_arbiter.md
# sr_flag_arbiter

Round-robin arbiter and sequencer that shares one bank of `NFLAG` SR status-flag flip-flops between `NREQ` requesters. Each requester asks to set or clear one flag. The block grants one request at a time and drives a single-cycle `s` or `r` pulse into the addressed flop. It then reads the flop's `q` back and reports completion or mismatch. It sits between the control agents and the SR flag bank, and is the only driver of the bank's `s`/`r` inputs.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `NFLAG`, 8, number of SR flags in the bank (power of two, 2..64)
- `IDXW`, `$clog2(NFLAG)`, flag index width (derived; not overridden)

- `clk`  in  1  rising-edge clock for all state
- `rst`  in  1  synchronous, active-high reset; sampled on rising `clk` edge
- `req`  in  `NREQ`  per-requester request, held until granted
- `req_op`  in  `NREQ`  per-requester operation: 1 = set, 0 = clear
- `req_idx`  in  `NREQ*IDXW`  per-requester flag index; requester k occupies bits `[k*IDXW +: IDXW]`
- `gnt`  out  `NREQ`  one-hot grant, single-cycle pulse
- `s`  out  `NFLAG`  set strobes to the flag bank, at most one bit high
- `r`  out  `NFLAG`  reset strobes to the flag bank, at most one bit high
- `q`  in  `NFLAG`  flag bank outputs, fed back for verification
- `done`  out  1  operation complete, single-cycle pulse
- `done_id`  out  `$clog2(NREQ)`  requester whose operation completed; valid only while `done` is high
- `err`  out  1  readback mismatch; valid only while `done` is high
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, GNT, DRV, CHK.
- **IDLE**
  - If any `req` bit is set: pick the winner round-robin, starting the search at pointer `rr_ptr`.
  - Latch the winner's id, `req_op` and `req_idx`, then go to GNT.
- **GNT**
  - `gnt[id]` = 1; go to DRV.
- **DRV**
  - If the latched op is set: `s[idx]` = 1. If it is clear: `r[idx]` = 1.
  - Go to CHK.
- **CHK**
  - `done` = 1, `done_id` = id, `err` = (`q[idx]` != op).
  - `rr_ptr` becomes id+1, modulo `NREQ`.
  - If any `req` is pending, arbitrate exactly as in IDLE and go to GNT. Otherwise go to IDLE.
- Arbitration in CHK uses the updated pointer, so the requester that just completed has lowest priority.
- Requester handshake:
  - Hold `req`, `req_op` and `req_idx` stable until `gnt` is seen.
  - Deassert `req` by the edge that ends the GNT cycle, or present a new request at that edge.
  - `req` changes in any other cycle are ignored except at arbitration points.
- `s` and `r` are never both nonzero in the same cycle. In every state except DRV, all strobe bits are 0.
- Idempotent operations (setting a flag that is already 1) are still driven and return `err` = 0.
- An out-of-range `req_idx` cannot occur because `NFLAG` is a power of two.

## Timing
- Reset values: state IDLE, `rr_ptr` = 0, `gnt` = 0, `s` = 0, `r` = 0, `done` = 0, `err` = 0, `done_id` = 0, `busy` = 0.
- Request sampled at edge E0 (state IDLE):
  - `gnt` is high in cycle 1.
  - The strobe is high in cycle 2.
  - The flop updates at the end of cycle 2.
  - `done`/`err` are high in cycle 3.
- Back-to-back throughput: one operation every 3 cycles.
- `rst` asserted in any state:
  - At the next edge, all outputs return to reset values and any in-flight operation is dropped, with no `done`.
  - A strobe already issued in DRV may have changed the flag; that is not reported.
- Simultaneous requests: exactly one grant, chosen by the pointer. Losers keep `req` high and are served within `NREQ`−1 further operations.

## Structure
- Package `sr_flag_pkg` holds:
  - the FSM state enum (IDLE, GNT, DRV, CHK)
  - the op constants `OP_SET` = 1, `OP_CLR` = 0
- Sub-module `rr_pick`: combinational round-robin picker taking `req` and `rr_ptr`, returning winner id and valid.
- The flag bank is outside this block.

## Test plan
- Reset, then a single request from requester 2 with set, idx 5 (`q` = 0) → `gnt` = 0100 in cycle 1, `s` = 0x20 in cycle 2, `done` = 1 / `done_id` = 2 / `err` = 0 in cycle 3.
- `req` = 1111 held continuously, starting from `rr_ptr` = 0 → grant order 0, 1, 2, 3, 0, spaced 3 cycles apart.
- Clear of idx 3 with the bank model holding `q[3]` = 1 (stuck) → `r` = 0x08 in DRV, then `done` = 1 and `err` = 1.
- `rst` asserted in the DRV cycle → the next cycle has `s` = `r` = 0, `busy` = 0 and no `done` pulse.
- Requester 1 issues set idx 0 then clear idx 0 back-to-back → never `s` and `r` high together, final `q[0]` = 0, two `done` pulses 3 cycles apart.
- Requester 0 sets an already-set flag → strobe is still driven and `err` = 0.
